// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store memory adapter.
//   lsu_size_e  - access size encoding carried on req_size
//   lsu_state_e - adapter FSM states
//   size_bytes  - byte count for a size code (0 for the illegal code)
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    BEAT1,
    CAPTURE,
    RESP
  } lsu_state_e;

  function automatic logic [2:0] size_bytes(lsu_size_e size);
    case (size)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      WORD:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering.
//   offset_i    - byte offset of the access inside its first word
//   size_i      - access size
//   unsigned_i  - zero-extend (1) or sign-extend (0) load data
//   wdata_i     - right-justified store data
//   rdata_raw_i - {second word, first word} as read from the RAM
//   mask_o      - 8-bit lane mask over the two words touched
//   wide_o      - store data shifted into its lanes over the two words
//   rdata_o     - extracted and extended load data
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  lsu_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] rdata_raw_i,
  output logic [7:0]  mask_o,
  output logic [63:0] wide_o,
  output logic [31:0] rdata_o
);

  logic [3:0]  base_mask;
  logic [31:0] shifted;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it holding and infer a latch.
  always_comb begin
    base_mask = 4'b0000;
    rdata_o   = 32'h0;
    case (size_i)
      BYTE:    base_mask = 4'b0001;
      HALF:    base_mask = 4'b0011;
      WORD:    base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase

    mask_o  = {4'b0000, base_mask} << offset_i;
    wide_o  = {32'h0, wdata_i} << {offset_i, 3'b000};
    // Only the low word of the realigned pair can hold load data.
    shifted = 32'(rdata_raw_i >> {offset_i, 3'b000});

    case (size_i)
      BYTE:    rdata_o = {{24{~unsigned_i & shifted[7]}},  shifted[7:0]};
      HALF:    rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      WORD:    rdata_o = shifted;
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter: CPU load/store port to word-wide single-port sync RAM.
//   Request side : req_valid/req_ready handshake, req_addr (byte address),
//                  req_write, req_size, req_unsigned, req_wdata.
//   Response side: rsp_valid one-cycle pulse with rsp_rdata and rsp_error.
//   RAM side     : mem_address (word), mem_enable, mem_byte_enable,
//                  mem_write_enable, mem_write_data, mem_read_data (data is
//                  valid the cycle after the beat).
// Accesses straddling a word boundary are issued as two consecutive beats.
// Illegal sizes and out-of-range or wrapping accesses respond with an error
// and never touch the RAM.
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_error,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]                mem_enable,
  output logic [3:0]                mem_byte_enable,
  output logic                      mem_write_enable,
  output logic [31:0]               mem_write_data,
  input  logic [31:0]               mem_read_data
);

  lsu_state_e                state_q;
  logic [1:0]                offset_q;
  logic [MEM_ADDR_WIDTH-1:0] w_q;
  lsu_size_e                 size_q;
  logic                      write_q;
  logic                      unsigned_q;
  logic                      split_q;
  logic [31:0]               wdata_q;
  logic [31:0]               lo_q;
  logic                      rsp_valid_q;
  logic                      rsp_error_q;
  logic [31:0]               rsp_rdata_q;

  // Decode of the request being offered; only used at the accept edge.
  lsu_size_e                 acc_size;
  logic [MEM_ADDR_WIDTH-1:0] acc_w;
  logic                      acc_split;
  logic                      acc_oor;
  logic                      acc_err;

  assign acc_size  = lsu_size_e'(req_size);
  assign acc_w     = req_addr[MEM_ADDR_WIDTH+1:2];
  assign acc_split = ({1'b0, req_addr[1:0]} + size_bytes(acc_size)) > 3'd4;
  assign acc_oor   = (req_addr >> (MEM_ADDR_WIDTH + 2)) != 32'h0;
  // A split starting in the last word would wrap to word 0: reject it.
  assign acc_err   = (acc_size == ILLEGAL) || acc_oor || (acc_split && (&acc_w));

  // The final beat's data arrives live on mem_read_data during CAPTURE; for a
  // split access the first beat was already parked in lo_q.
  logic [63:0] comb_d;
  logic [7:0]  mask;
  logic [63:0] wide;
  logic [31:0] ext_rdata;

  assign comb_d = split_q ? {mem_read_data, lo_q} : {32'h0, mem_read_data};

  lsu_lane_align u_lane_align (
    .offset_i    (offset_q),
    .size_i      (size_q),
    .unsigned_i  (unsigned_q),
    .wdata_i     (wdata_q),
    .rdata_raw_i (comb_d),
    .mask_o      (mask),
    .wide_o      (wide),
    .rdata_o     (ext_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the read buffer is a couple of flops, not a memory array, so it is
  // reset along with everything else and never leaks stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      offset_q    <= 2'b00;
      w_q         <= '0;
      size_q      <= BYTE;
      write_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      split_q     <= 1'b0;
      wdata_q     <= 32'h0;
      lo_q        <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            offset_q   <= req_addr[1:0];
            w_q        <= acc_w;
            size_q     <= acc_size;
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            split_q    <= acc_split;
            wdata_q    <= req_wdata;
            if (acc_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end else begin
              state_q <= BEAT0;
            end
          end
        end
        BEAT0: state_q <= split_q ? BEAT1 : CAPTURE;
        BEAT1: begin
          lo_q    <= mem_read_data;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          if (!split_q) lo_q <= mem_read_data;
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= write_q ? 32'h0 : ext_rdata;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= 32'h0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

  // RAM drive depends only on state and registered request fields.
  always_comb begin
    mem_address      = '0;
    mem_byte_enable  = 4'b0000;
    mem_write_enable = 1'b0;
    mem_write_data   = 32'h0;
    case (state_q)
      BEAT0: begin
        mem_address      = w_q;
        mem_byte_enable  = mask[3:0];
        mem_write_enable = write_q;
        mem_write_data   = wide[31:0];
      end
      BEAT1: begin
        mem_address      = w_q + MEM_ADDR_WIDTH'(1);
        mem_byte_enable  = mask[7:4];
        mem_write_enable = write_q;
        mem_write_data   = wide[63:32];
      end
      default: ;
    endcase
    mem_enable = mem_byte_enable;
  end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// tb_lsu_mem_adapter: scoreboard bench for lsu_mem_adapter.
// The driver computes every expected RAM beat and response from a byte-level
// memory model and queues them; a negedge monitor pops and compares whenever
// the DUT enables the RAM or pulses rsp_valid.
module tb_lsu_mem_adapter;

  localparam int AW    = 14;
  localparam int BYTES = 1 << (AW + 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = '0;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_enable;
  logic [3:0]    mem_byte_enable;
  logic          mem_write_enable;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data = '0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [AW-1:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] data;
  } beat_t;

  rsp_t  rsp_q[$];
  beat_t beat_q[$];
  rsp_t  mon_r;
  beat_t mon_b;
  logic [31:0] mon_lanes;

  bit [31:0] ram [1 << AW];
  bit [31:0] ram_w;
  bit [7:0]  ref_mem [BYTES];

  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;
  bit partial_store = 1'b0;

  lsu_mem_adapter #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .mem_address      (mem_address),
    .mem_enable       (mem_enable),
    .mem_byte_enable  (mem_byte_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAM: read returns the pre-write word.
  always @(posedge clk) begin
    if (mem_enable != 4'b0000) begin
      ram_w = ram[mem_address];
      mem_read_data <= ram_w;
      if (mem_write_enable) begin
        for (int l = 0; l < 4; l++)
          if (mem_byte_enable[l]) ram_w[8*l +: 8] = mem_write_data[8*l +: 8];
        ram[mem_address] <= ram_w;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every RAM beat and every response against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_enable != 4'b0000) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", 64'(mem_enable), 64'd0);
        end else begin
          mon_b = beat_q.pop_front();
          mon_lanes = {{8{mon_b.be[3]}}, {8{mon_b.be[2]}}, {8{mon_b.be[1]}}, {8{mon_b.be[0]}}};
          check("beat_cycle", 64'(cyc), 64'(mon_b.cyc));
          check("beat_addr", 64'(mem_address), 64'(mon_b.addr));
          check("beat_be", 64'(mem_byte_enable), 64'(mon_b.be));
          check("beat_en_eq_be", 64'(mem_enable), 64'(mon_b.be));
          check("beat_we", 64'(mem_write_enable), 64'(mon_b.we));
          if (mon_b.we) check("beat_wdata", 64'(mem_write_data & mon_lanes), 64'(mon_b.data & mon_lanes));
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          mon_r = rsp_q.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(mon_r.cyc));
          check("rsp_error", 64'(rsp_error), 64'(mon_r.err));
          check("rsp_rdata", 64'(rsp_rdata), 64'(mon_r.rdata));
        end
      end
    end
  end

  // Issue one request as soon as the DUT is ready; valid is left high so
  // consecutive calls present back-to-back traffic. t = offer cycle.
  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                       input logic un, input logic [31:0] wd, output int t);
    int          guard;
    int          n;
    int          first;
    int          lastw;
    bit          err;
    bit          split;
    logic [31:0] v;
    rsp_t        r;
    beat_t       b;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    check("ready_timeout", 64'(guard >= 20), 64'd0);
    t = cyc;
    req_valid    = 1'b1;
    req_addr     = a;
    req_size     = sz;
    req_write    = wr;
    req_unsigned = un;
    req_wdata    = wd;

    n     = (sz == 2'b11) ? 0 : (1 << sz);
    err   = (sz == 2'b11) || (longint'(a) + n - 1 >= longint'(BYTES));
    split = !err && ((a % 4) + n > 4);
    r.cyc   = t + (err ? 1 : (split ? 4 : 3));
    r.err   = err;
    r.rdata = 32'h0;
    if (!err) begin
      first = int'(a >> 2);
      lastw = int'((a + n - 1) >> 2);
      for (int w = first; w <= lastw; w++) begin
        b.cyc  = t + 1 + (w - first);
        b.addr = AW'(w);
        b.we   = wr;
        b.be   = 4'b0000;
        b.data = 32'h0;
        for (int i = 0; i < n; i++) begin
          if (int'((a + i) >> 2) == w) begin
            b.be[(a + i) % 4] = 1'b1;
            b.data[8*((a + i) % 4) +: 8] = wd[8*i +: 8];
          end
        end
        beat_q.push_back(b);
      end
      if (wr) begin
        for (int i = 0; i < n; i++)
          if (!partial_store || int'((a + i) >> 2) == first) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
        if (!un && n < 4 && v[8*n - 1])
          for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        r.rdata = v;
      end
    end
    rsp_q.push_back(r);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual t=%0t required finish before 200000", $time);
    $fatal(1);
  end

  initial begin
    int t1;
    int t2;
    int sel;
    logic [31:0] a;
    logic [1:0]  sz;

    // Reset values while rst_n is held low.
    #3;
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_error", 64'(rsp_error), 64'd0);
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("reset_mem_enable", 64'(mem_enable), 64'd0);
    check("reset_mem_be", 64'(mem_byte_enable), 64'd0);
    check("reset_mem_we", 64'(mem_write_enable), 64'd0);
    check("reset_mem_addr", 64'(mem_address), 64'd0);
    check("reset_mem_wdata", 64'(mem_write_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Aligned word store then load, held valid: accepts 4 cycles apart.
    issue(32'h10, 2'b10, 1'b1, 1'b0, 32'hDEADBEEF, t1);
    issue(32'h10, 2'b10, 1'b0, 1'b0, 32'h0, t2);
    check("b2b_gap_aligned", 64'(t2 - t1), 64'd4);

    // Byte sign/zero extension from word 1 = 0x80FF7F01.
    issue(32'h04, 2'b10, 1'b1, 1'b0, 32'h80FF7F01, t1);
    issue(32'h06, 2'b00, 1'b0, 1'b0, 32'h0, t1);
    issue(32'h06, 2'b00, 1'b0, 1'b1, 32'h0, t1);
    issue(32'h04, 2'b00, 1'b0, 1'b0, 32'h0, t1);
    issue(32'h05, 2'b01, 1'b0, 1'b0, 32'h0, t1);

    // Misaligned half split store, then load back; split gap is 5.
    issue(32'h07, 2'b01, 1'b1, 1'b0, 32'h0000BBAA, t1);
    issue(32'h07, 2'b01, 1'b0, 1'b0, 32'h0, t2);
    check("b2b_gap_split", 64'(t2 - t1), 64'd5);

    // Misaligned word split load across words 2 and 3.
    issue(32'h08, 2'b10, 1'b1, 1'b0, 32'h44332211, t1);
    issue(32'h0C, 2'b10, 1'b1, 1'b0, 32'h88776655, t1);
    issue(32'h0A, 2'b10, 1'b0, 1'b0, 32'h0, t1);

    // Errors: illegal size, out of range, wrapping split; error gap is 2.
    issue(32'h20, 2'b11, 1'b0, 1'b0, 32'h0, t1);
    issue(32'h00010000, 2'b10, 1'b0, 1'b0, 32'h0, t2);
    check("b2b_gap_error", 64'(t2 - t1), 64'd2);
    issue(32'h0000FFFE, 2'b10, 1'b0, 1'b0, 32'h0, t1);
    issue(32'h0000FFFF, 2'b01, 1'b1, 1'b0, 32'h1234, t1);
    // Top-of-memory accesses that stay in range.
    issue(32'h0000FFFE, 2'b01, 1'b1, 1'b0, 32'h5AA5, t1);
    issue(32'h0000FFFF, 2'b00, 1'b0, 1'b0, 32'h0, t1);
    issue(32'h0000FFFC, 2'b10, 1'b0, 1'b1, 32'h0, t1);
    idle(2);

    // Reset pulse during BEAT1 of a split store; beat 0 stays written.
    partial_store = 1'b1;
    issue(32'h22, 2'b10, 1'b1, 1'b0, 32'hCAFEF00D, t1);
    partial_store = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("abort_mem_enable", 64'(mem_enable), 64'd0);
    check("abort_mem_be", 64'(mem_byte_enable), 64'd0);
    check("abort_mem_we", 64'(mem_write_enable), 64'd0);
    check("abort_mem_addr", 64'(mem_address), 64'd0);
    check("abort_mem_wdata", 64'(mem_write_data), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_beats_left", 64'(beat_q.size()), 64'd0);
    rsp_q.delete();
    beat_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    idle(6);
    check("post_abort_ready", 64'(req_ready), 64'd1);
    issue(32'h20, 2'b10, 1'b0, 1'b0, 32'h0, t1);
    issue(32'h24, 2'b10, 1'b0, 1'b0, 32'h0, t1);

    // Randomized traffic around the bottom and top of memory.
    for (int k = 0; k < 300; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = 32'($urandom_range(0, 63));
      else if (sel < 9) a = 32'h0000FFF0 + 32'($urandom_range(0, 15));
      else              a = $urandom;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      issue(a, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, t1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(8);
    check("rsp_pending", 64'(rsp_q.size()), 64'd0);
    check("beat_pending", 64'(beat_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
